// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART-ALU command path.
package uart_alu_pkg;

  localparam int unsigned CMD_W   = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned OPC_W   = 6;

  // Command bytes recognised in IDLE
  localparam logic [CMD_W-1:0] CMD_SET_A  = 8'h01;
  localparam logic [CMD_W-1:0] CMD_SET_B  = 8'h02;
  localparam logic [CMD_W-1:0] CMD_SET_OP = 8'h03;
  localparam logic [CMD_W-1:0] CMD_EXEC   = 8'h04;

  // ALU opcodes shared with the ALU and benches
  localparam logic [OPC_W-1:0] OP_ADD = 6'h20;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h22;
  localparam logic [OPC_W-1:0] OP_AND = 6'h24;
  localparam logic [OPC_W-1:0] OP_OR  = 6'h25;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_A  = 3'd1,
    ST_WAIT_B  = 3'd2,
    ST_WAIT_OP = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bus bundle between uart_rx/uart_tx/ALU and the command parser.
interface uart_alu_interface_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned OP_W = 6
);

  logic [N-1:0]    rx_data;
  logic            rx_done;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [OP_W-1:0] alu_op;
  logic [N-1:0]    alu_result;
  logic [N-1:0]    tx_data;
  logic            tx_start;
  logic            tx_done;
  logic            cmd_err;
  logic            busy;

  // Environment side: UART receiver/transmitter and ALU
  modport master (
    output rx_data, rx_done, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, cmd_err, busy
  );

  // Command parser side
  modport slave (
    input  rx_data, rx_done, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_data, tx_start, cmd_err, busy
  );

endinterface

// File: rtl/uart_alu_interface.sv
// Command-parsing FSM: turns received bytes into ALU operand/opcode
// loads and hands EXEC results to the transmitter.
module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned OP_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_alu_interface_if.slave  bus
);

  state_t          state_q;
  logic [N-1:0]    alu_a_q;
  logic [N-1:0]    alu_b_q;
  logic [OP_W-1:0] alu_op_q;
  logic [N-1:0]    tx_data_q;
  logic            tx_start_q;
  logic            cmd_err_q;

  // Parser FSM with operand, opcode and transmit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_done) begin
            if (bus.rx_data == N'(CMD_SET_A)) begin
              state_q <= ST_WAIT_A;
            end else if (bus.rx_data == N'(CMD_SET_B)) begin
              state_q <= ST_WAIT_B;
            end else if (bus.rx_data == N'(CMD_SET_OP)) begin
              state_q <= ST_WAIT_OP;
            end else if (bus.rx_data == N'(CMD_EXEC)) begin
              state_q <= ST_SEND;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_A: begin
          if (bus.rx_done) begin
            alu_a_q <= bus.rx_data;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_B: begin
          if (bus.rx_done) begin
            alu_b_q <= bus.rx_data;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (bus.rx_done) begin
            alu_op_q <= bus.rx_data[OP_W-1:0];
            state_q  <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // Operands are already stable here, so the ALU result is settled
          tx_data_q  <= bus.alu_result;
          tx_start_q <= 1'b1;
          state_q    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Received bytes are dropped while a transmission is pending
          if (bus.tx_done) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.cmd_err  = cmd_err_q;
  // busy decodes the state register directly
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for the UART-ALU command parser.
module tb_uart_alu_interface;
  import uart_alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   tx_count;

  uart_alu_interface_if #(.N(8), .OP_W(6)) bus ();

  uart_alu_interface #(.N(8), .OP_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Sibling ALU model
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  // Count tx_start pulses at the edge that ends each cycle
  always @(posedge clk) begin
    if (bus.tx_start === 1'b1) tx_count <= tx_count + 1;
  end

  typedef struct {
    logic [7:0] b;
    logic       exp_err;
    logic       exp_busy;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [5:0] exp_op;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  // EXEC and check the start pulse and latched result
  task automatic do_exec(input logic [7:0] exp);
    send_byte(CMD_EXEC);
    check("exec_busy", 32'(bus.busy), 32'd1);
    check("exec_no_early_start", 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    check("tx_start", 32'(bus.tx_start), 32'd1);
    check("tx_data", 32'(bus.tx_data), 32'(exp));
    @(negedge clk);
    check("tx_start_one_cycle", 32'(bus.tx_start), 32'd0);
    check("tx_data_held", 32'(bus.tx_data), 32'(exp));
  endtask

  initial begin
    int c0;
    checks   = 0;
    failures = 0;
    tx_count = 0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    reset = 1'b1;

    vecs[0] = '{8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 6'h00};
    vecs[1] = '{8'h05, 1'b0, 1'b0, 8'h05, 8'h00, 6'h00};
    vecs[2] = '{8'h02, 1'b0, 1'b1, 8'h05, 8'h00, 6'h00};
    vecs[3] = '{8'h03, 1'b0, 1'b0, 8'h05, 8'h03, 6'h00};
    vecs[4] = '{8'h03, 1'b0, 1'b1, 8'h05, 8'h03, 6'h00};
    vecs[5] = '{8'h20, 1'b0, 1'b0, 8'h05, 8'h03, 6'h20};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h05, 8'h03, 6'h20};
    vecs[7] = '{8'h03, 1'b0, 1'b1, 8'h05, 8'h03, 6'h20};
    vecs[8] = '{8'hE2, 1'b0, 1'b0, 8'h05, 8'h03, 6'h22};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Operand/opcode loads, unknown command, opcode truncation
    c0 = tx_count;
    for (int i = 0; i < 9; i++) begin
      send_byte(vecs[i].b);
      check($sformatf("v%0d_cmd_err", i), 32'(bus.cmd_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_alu_a", i), 32'(bus.alu_a), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_alu_b", i), 32'(bus.alu_b), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_alu_op", i), 32'(bus.alu_op), 32'(vecs[i].exp_op));
      if (vecs[i].exp_err) begin
        @(negedge clk);
        check($sformatf("v%0d_cmd_err_once", i), 32'(bus.cmd_err), 32'd0);
      end
    end
    @(negedge clk);
    check("no_tx_during_loads", 32'(tx_count - c0), 32'd0);

    // SUB 5-3 = 2, then ADD 5+3 = 8
    c0 = tx_count;
    do_exec(8'h02);
    repeat (2) @(negedge clk);
    check("sub_busy_until_done", 32'(bus.busy), 32'd1);
    pulse_tx_done();
    check("sub_idle_after_done", 32'(bus.busy), 32'd0);
    check("sub_one_start", 32'(tx_count - c0), 32'd1);

    send_byte(CMD_SET_OP);
    send_byte(8'h20);
    check("op_add", 32'(bus.alu_op), 32'h20);
    c0 = tx_count;
    do_exec(8'h08);
    pulse_tx_done();
    check("add_idle_after_done", 32'(bus.busy), 32'd0);
    check("add_one_start", 32'(tx_count - c0), 32'd1);

    // tx_done in IDLE is ignored
    pulse_tx_done();
    check("txdone_idle_busy", 32'(bus.busy), 32'd0);

    // Reset mid-command aborts it and clears operands
    send_byte(CMD_SET_A);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
    send_byte(8'h09);
    check("after_rst_cmd_err", 32'(bus.cmd_err), 32'd1);
    check("after_rst_alu_a", 32'(bus.alu_a), 32'd0);
    c0 = tx_count;
    send_byte(CMD_SET_A);
    send_byte(CMD_EXEC);
    check("exec_as_data", 32'(bus.alu_a), 32'h04);
    check("exec_as_data_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("exec_as_data_no_tx", 32'(tx_count - c0), 32'd0);

    // Byte during WAIT_TX is dropped: 0x0C | 0x0A = 0x0E
    send_byte(CMD_SET_A);  send_byte(8'h0C);
    send_byte(CMD_SET_B);  send_byte(8'h0A);
    send_byte(CMD_SET_OP); send_byte(8'h25);
    c0 = tx_count;
    do_exec(8'h0E);
    send_byte(CMD_SET_B);
    check("waittx_no_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("waittx_alu_b", 32'(bus.alu_b), 32'h0A);
    check("waittx_tx_data", 32'(bus.tx_data), 32'h0E);
    check("waittx_busy", 32'(bus.busy), 32'd1);
    pulse_tx_done();
    check("waittx_idle", 32'(bus.busy), 32'd0);
    check("waittx_tx_data_after", 32'(bus.tx_data), 32'h0E);
    check("waittx_one_start", 32'(tx_count - c0), 32'd1);

    // Simultaneous rx_done and tx_done: tx_done wins, byte dropped
    c0 = tx_count;
    do_exec(8'h0E);
    @(negedge clk);
    bus.rx_data = CMD_SET_A;
    bus.rx_done = 1'b1;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    check("simul_idle", 32'(bus.busy), 32'd0);
    check("simul_no_cmd_err", 32'(bus.cmd_err), 32'd0);
    repeat (3) @(negedge clk);
    check("simul_still_idle", 32'(bus.busy), 32'd0);
    check("simul_alu_a", 32'(bus.alu_a), 32'h0C);
    check("simul_one_start", 32'(tx_count - c0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
